// File: rtl/osd_string_sched.sv
// osd_string_sched: round-robin scheduler sharing one string writer with a region-clear engine
module osd_string_sched #(
  parameter int         NUM_REQ     = 4,
  parameter int         IDX_W       = 6,
  parameter int         ADDR_W      = 11,
  parameter int         CLR_LEN     = 32,
  parameter logic [7:0] FILL_CHAR   = 8'h20,
  parameter int         ACK_TIMEOUT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*IDX_W-1:0]  req_index,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  input  logic                      clr_req,
  input  logic [ADDR_W-1:0]         clr_addr,
  output logic                      clr_done,
  output logic                      wr_start,
  output logic [IDX_W-1:0]          wr_string_index,
  output logic [ADDR_W-1:0]         wr_base_addr,
  input  logic                      wr_busy,
  input  logic                      w_en,
  input  logic [ADDR_W-1:0]         w_addr,
  input  logic [7:0]                w_data,
  output logic                      osd_wr_en,
  output logic [ADDR_W-1:0]         osd_wr_addr,
  output logic [7:0]                osd_wr_data
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int CW = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RELEASE, CLEAR} state_t;
  state_t              r_state, w_next;
  logic [GW-1:0]       r_ptr, r_gnt, w_gnt, w_cand;
  logic                w_any, w_timeout;
  logic [TW-1:0]       r_tcnt;
  logic [CW-1:0]       r_ccnt;
  logic [ADDR_W-1:0]   r_clr_addr, r_base;
  logic [IDX_W-1:0]    r_idx;
  logic [NUM_REQ-1:0]  r_done;
  logic                r_start, r_err, r_clr_done;
  logic [IDX_W-1:0]    w_slot_idx [NUM_REQ];
  logic [ADDR_W-1:0]   w_slot_addr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign w_slot_idx[i]  = req_index[i*IDX_W +: IDX_W];
    assign w_slot_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
  end
  // first requesting slot at or after the round-robin pointer, scanned downward so the nearest wins
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = '0;
    w_cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = GW'((int'(r_ptr) + k) % NUM_REQ);
      if (req[w_cand]) begin
        w_any = 1'b1;
        w_gnt = w_cand;
      end
    end
  end
  // next-state logic; new work is only accepted once the shared writer is idle
  always_comb begin
    w_next    = r_state;
    w_timeout = r_state == WAIT_ACK && !wr_busy && r_tcnt == TW'(ACK_TIMEOUT - 1);
    case (r_state)
      IDLE:      w_next = wr_busy ? IDLE : clr_req ? CLEAR : w_any ? ISSUE : IDLE;
      ISSUE:     w_next = WAIT_ACK;
      WAIT_ACK:  w_next = (r_tcnt == TW'(ACK_TIMEOUT)) ? RELEASE : wr_busy ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: w_next = wr_busy ? WAIT_DONE : RELEASE;
      RELEASE:   w_next = IDLE;
      CLEAR:     w_next = (r_ccnt == CW'(CLR_LEN - 1)) ? IDLE : CLEAR;
      default:   w_next = IDLE;
    endcase
  end
  // state, grant latching, counters and registered pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_tcnt     <= '0;
      r_ccnt     <= '0;
      r_clr_addr <= '0;
      r_idx      <= '0;
      r_base     <= '0;
      r_done     <= '0;
      r_start    <= 1'b0;
      r_err      <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_start    <= w_next == ISSUE;
      r_err      <= w_timeout;
      r_done     <= (w_next == RELEASE) ? NUM_REQ'(1) << r_gnt : '0;
      r_clr_done <= r_state == CLEAR && w_next == IDLE;
      if (r_state == IDLE && w_next == ISSUE) begin
        r_gnt  <= w_gnt;
        r_ptr  <= GW'((int'(w_gnt) + 1) % NUM_REQ);
        r_idx  <= w_slot_idx[w_gnt];
        r_base <= w_slot_addr[w_gnt];
      end
      if (r_state == IDLE && w_next == CLEAR) begin
        r_clr_addr <= clr_addr;
        r_ccnt     <= '0;
      end else if (r_state == CLEAR) begin
        r_ccnt <= r_ccnt + CW'(1);
      end
      r_tcnt <= (r_state == ISSUE) ? '0 :
                (r_state == WAIT_ACK && !wr_busy && r_tcnt != TW'(ACK_TIMEOUT)) ? r_tcnt + TW'(1) : r_tcnt;
    end
  end
  assign done            = r_done;
  assign err             = r_err;
  assign clr_done        = r_clr_done;
  assign wr_start        = r_start;
  assign wr_string_index = r_idx;
  assign wr_base_addr    = r_base;
  assign osd_wr_en       = (r_state == CLEAR) ? 1'b1 : w_en;
  assign osd_wr_addr     = (r_state == CLEAR) ? r_clr_addr + ADDR_W'(r_ccnt) : w_addr;
  assign osd_wr_data     = (r_state == CLEAR) ? FILL_CHAR : w_data;
endmodule

// File: tb/tb_osd_string_sched.sv
// tb_osd_string_sched: randomized scoreboard bench with a writer model and responsive requesters
module tb_osd_string_sched;
  localparam int N = 4, IW = 6, AW = 11, CL = 32;
  localparam int K_START = 0, K_ERR = 1, K_DONE = 2, K_CLRW = 3, K_CDONE = 4;
  logic clk = 0, reset = 1;
  logic [N-1:0] req = '0;
  logic [N*IW-1:0] req_index = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0] done;
  logic err, clr_done, wr_start, osd_wr_en;
  logic clr_req = 0;
  logic [AW-1:0] clr_addr = '0;
  logic [IW-1:0] wr_string_index;
  logic [AW-1:0] wr_base_addr, osd_wr_addr;
  logic [7:0] osd_wr_data;
  logic wr_busy = 0, w_en = 0;
  logic [AW-1:0] w_addr = '0;
  logic [7:0] w_data = '0;

  osd_string_sched dut (
    .clk(clk), .reset(reset), .req(req), .req_index(req_index), .req_addr(req_addr),
    .done(done), .err(err), .clr_req(clr_req), .clr_addr(clr_addr), .clr_done(clr_done),
    .wr_start(wr_start), .wr_string_index(wr_string_index), .wr_base_addr(wr_base_addr),
    .wr_busy(wr_busy), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .osd_wr_en(osd_wr_en), .osd_wr_addr(osd_wr_addr), .osd_wr_data(osd_wr_data));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int k; int a; int b;} ev_t;
  ev_t q[$];
  int wq[$];
  string knm[5] = '{"start", "err", "done", "clr_write", "clr_done"};
  int nchk = 0, nbad = 0;
  int t_ready = 0, t_start = 0, t_err = 0, t_fall = 0, nclr = 0, m_ptr = 0;
  bit had_err = 0, mon_en = 0, busy_q = 0;
  logic [IW-1:0] sidx [N];
  logic [AW-1:0] sadr [N];
  int md [N];

  task automatic chk(input string nm, input bit ok, input string got, input string exp);
    nchk++;
    if (!ok) begin
      nbad++;
      $display("FAIL %s: got %s, required %s", nm, got, exp);
    end
  endtask

  // scoreboard pop: value and cycle of each observed event against the queued expectation
  task automatic take(input int k, input int a, input int b);
    ev_t e;
    int et;
    if (q.size() == 0) begin
      chk("unexpected", 0, $sformatf("%s a=%0h b=%0h @%0d", knm[k], a, b, cyc), "no event");
      return;
    end
    e = q.pop_front();
    case (e.k)
      K_START: et = t_ready + 1;
      K_ERR:   et = t_start + 5;
      K_DONE:  et = had_err ? t_err + 1 : t_fall + 1;
      K_CLRW:  et = t_ready + 1 + nclr;
      default: et = t_ready + 1 + CL;
    endcase
    chk(knm[e.k], e.k == k && e.a == a && e.b == b && cyc == et,
        $sformatf("%s a=%0h b=%0h @%0d", knm[k], a, b, cyc),
        $sformatf("%s a=%0h b=%0h @%0d", knm[e.k], e.a, e.b, et));
    case (k)
      K_START: t_start = cyc;
      K_ERR:   begin t_err = cyc; had_err = 1; end
      K_DONE:  begin had_err = 0; t_ready = cyc + 1; end
      K_CLRW:  nclr++;
      default: begin t_ready = cyc; nclr = 0; end
    endcase
  endtask

  // monitor
  initial forever begin
    @(negedge clk);
    if (busy_q && !wr_busy) t_fall = cyc;
    busy_q = wr_busy;
    if (mon_en) begin
      if (w_en)
        chk("passthru", osd_wr_en && osd_wr_addr == w_addr && osd_wr_data == w_data,
            $sformatf("%b/%0h/%0h", osd_wr_en, osd_wr_addr, osd_wr_data),
            $sformatf("1/%0h/%0h", w_addr, w_data));
      if (err) take(K_ERR, 0, 0);
      if (done != 0) take(K_DONE, int'(done), 0);
      if (clr_done) take(K_CDONE, 0, 0);
      if (wr_start) take(K_START, int'(wr_string_index), int'(wr_base_addr));
      if (osd_wr_en && !w_en) take(K_CLRW, int'(osd_wr_addr), int'(osd_wr_data));
    end
  end

  // writer model: mode -1 never goes busy, else dly*100+len
  initial forever begin
    @(negedge clk);
    if (wr_start) begin
      int m;
      m = (wq.size() != 0) ? wq.pop_front() : -1;
      if (m >= 0) begin
        repeat (m / 100) @(posedge clk);
        #1 wr_busy = 1;
        w_en = 1'($urandom); w_addr = AW'($urandom); w_data = 8'($urandom);
        repeat (m % 100 - 1) begin
          @(posedge clk);
          #1 w_en = 1'($urandom); w_addr = AW'($urandom); w_data = 8'($urandom);
        end
        @(posedge clk);
        #1 wr_busy = 0; w_en = 0;
      end
    end
  end

  // requesters drop their bit in response to done
  initial forever begin
    @(negedge clk);
    if (done != 0) begin
      logic [N-1:0] m;
      m = done;
      @(posedge clk);
      #1 req = req & ~m;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drain();
    for (int k = 0; k < 4000 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain", 0, $sformatf("%0d pending", q.size()), "0 pending");
      q.delete();
      had_err = 0;
      nclr = 0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic rnd_slots();
    for (int i = 0; i < N; i++) begin
      sidx[i] = IW'($urandom);
      sadr[i] = AW'($urandom);
      md[i] = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(1, 3) * 100 + $urandom_range(1, 12);
    end
  endtask

  // expected order: set bits taken cyclically from the model pointer, clear first
  task automatic batch(input logic [N-1:0] mask, input bit clr, input logic [AW-1:0] ca);
    int g, base;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      req_index[i*IW +: IW] = sidx[i];
      req_addr[i*AW +: AW] = sadr[i];
    end
    t_ready = cyc;
    if (clr) begin
      for (int k = 0; k < CL; k++) q.push_back('{K_CLRW, int'(AW'(ca + AW'(k))), 32'h20});
      q.push_back('{K_CDONE, 0, 0});
      clr_addr = ca;
      clr_req = 1;
    end
    base = m_ptr;
    for (int n = 0; n < N; n++) begin
      g = (base + n) % N;
      if (mask[g]) begin
        q.push_back('{K_START, int'(sidx[g]), int'(sadr[g])});
        if (md[g] < 0) q.push_back('{K_ERR, 0, 0});
        q.push_back('{K_DONE, 1 << g, 0});
        wq.push_back(md[g]);
        m_ptr = (g + 1) % N;
      end
    end
    req = mask;
    if (clr) begin
      @(posedge clk);
      #1 clr_req = 0;
    end
    drain();
  endtask

  initial begin
    logic [N-1:0] mk;
    int f;
    w_en = 1; w_addr = 11'h123; w_data = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_regs", {wr_start, done, err, clr_done, wr_string_index, wr_base_addr} == '0,
        $sformatf("%0h", {wr_start, done, err, clr_done, wr_string_index, wr_base_addr}), "0");
    chk("reset_passthru", osd_wr_en && osd_wr_addr == 11'h123 && osd_wr_data == 8'h5A,
        $sformatf("%b/%0h/%0h", osd_wr_en, osd_wr_addr, osd_wr_data), "1/123/5a");
    @(posedge clk);
    #1 reset = 0; w_en = 0; mon_en = 1;
    repeat (2) @(negedge clk);
    rnd_slots();
    for (int i = 0; i < N; i++) md[i] = 100 + $urandom_range(1, 8);
    batch(4'b1111, 0, '0);
    batch(4'b1001, 0, '0);
    sidx[2] = 6'd5; sadr[2] = 11'h040; md[2] = 110;
    batch(4'b0100, 0, '0);
    md[0] = 203;
    batch(4'b0001, 1, 11'h7F0);
    md[1] = -1;
    batch(4'b0010, 0, '0);
    for (int t = 0; t < 25; t++) begin
      rnd_slots();
      mk = N'($urandom);
      if (mk == 0 && ($urandom_range(0, 1) == 0)) mk = 4'b0001;
      batch(mk, (mk == 0) || ($urandom_range(0, 3) == 0), AW'($urandom));
    end
    rnd_slots();
    @(posedge clk);
    #1;
    req_index[2*IW +: IW] = sidx[2];
    req_addr[2*AW +: AW] = sadr[2];
    t_ready = cyc;
    q.push_back('{K_START, int'(sidx[2]), int'(sadr[2])});
    wq.push_back(140);
    req = 4'b0100;
    for (int k = 0; k < 50 && !wr_busy; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("busy_before_reset", wr_busy == 1, $sformatf("%b", wr_busy), "1");
    @(posedge clk);
    #1 mon_en = 0; reset = 1;
    @(posedge clk);
    #1 reset = 0; q.delete(); had_err = 0; nclr = 0;
    @(negedge clk);
    chk("reset_mid_regs", {wr_start, done, err, clr_done, wr_string_index, wr_base_addr} == '0,
        $sformatf("%0h", {wr_start, done, err, clr_done, wr_string_index, wr_base_addr}), "0");
    for (int k = 0; k < 100 && wr_busy; k++) begin
      chk("quiet_while_busy", !wr_start && done == 0 && !clr_done,
          $sformatf("start=%b done=%b clr_done=%b", wr_start, done, clr_done), "all 0");
      @(negedge clk);
    end
    f = cyc;
    chk("busy_released", wr_busy == 0, $sformatf("%b", wr_busy), "0");
    @(posedge clk);
    #1;
    t_ready = f;
    q.push_back('{K_START, int'(sidx[2]), int'(sadr[2])});
    q.push_back('{K_DONE, 4, 0});
    wq.push_back(105);
    m_ptr = 3;
    mon_en = 1;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end
endmodule
